// File: rtl/fdivsqrt_cycle_ctrl.sv
// Cycle-count and sequencing controller for the radix-2^LOGR fdivsqrt datapath.
// Derives the iteration count from format/op, then runs an IDLE/BUSY/DONE FSM.
module fdivsqrt_cycle_ctrl #(
  parameter int unsigned LOGR        = 2,
  parameter int unsigned DIVCOPIES   = 2,
  parameter int unsigned NF_H        = 10,
  parameter int unsigned NF_S        = 23,
  parameter int unsigned NF_D        = 52,
  parameter int unsigned NF_Q        = 112,
  parameter int unsigned FMTBITS     = 2,
  parameter int unsigned DIVBLEN     = 8,
  parameter int unsigned DURLEN      = 6,
  parameter int unsigned IDIV_ON_FPU = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_e,
  input  logic [FMTBITS-1:0] fmt_e,
  input  logic               sqrt_e,
  input  logic               int_div_e,
  input  logic [DIVBLEN-1:0] int_result_bits_e,
  input  logic               special_case_e,
  input  logic               stall_m,
  input  logic               flush_e,
  output logic               busy,
  output logic               step,
  output logic               first_step,
  output logic               done,
  output logic [DURLEN-1:0]  cycles_e,
  output logic [DURLEN-1:0]  cycles_left
);

  localparam int unsigned RK = LOGR * DIVCOPIES;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [DURLEN-1:0]  cycles_left_q, cycles_left_d;
  logic               first_q, first_d;
  logic [DIVBLEN-1:0] nf;
  logic [DIVBLEN-1:0] bits;
  logic [DIVBLEN-1:0] quot;

  // Result-bit count and cycle count for the op currently presented at E.
  always_comb begin
    nf = DIVBLEN'(NF_S);
    case (fmt_e[1:0])
      2'b00:   nf = DIVBLEN'(NF_S);
      2'b01:   nf = DIVBLEN'(NF_D);
      2'b10:   nf = DIVBLEN'(NF_H);
      default: nf = DIVBLEN'(NF_Q);
    endcase

    if ((IDIV_ON_FPU != 0) && int_div_e) begin
      bits = int_result_bits_e;
    end else if (sqrt_e) begin
      bits = nf + DIVBLEN'(2);
    end else begin
      bits = nf + DIVBLEN'(2 + LOGR);
    end

    quot     = (bits - DIVBLEN'(1)) / DIVBLEN'(RK);
    cycles_e = (bits == '0) ? DURLEN'(1) : DURLEN'(quot + DIVBLEN'(1));
  end

  always_comb begin
    state_d       = state_q;
    cycles_left_d = cycles_left_q;
    first_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_e) begin
          if (special_case_e) begin
            state_d = StDone;
          end else begin
            state_d       = StBusy;
            cycles_left_d = cycles_e;
            first_d       = 1'b1;
          end
        end
      end
      StBusy: begin
        cycles_left_d = cycles_left_q - DURLEN'(1);
        // <= 1 also guards against a wrapped count if cycles_e ever truncates to 0
        if (cycles_left_q <= DURLEN'(1)) begin
          state_d       = StDone;
          cycles_left_d = '0;
        end
      end
      StDone: begin
        if (!stall_m) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_e) begin
      state_d       = StIdle;
      cycles_left_d = '0;
      first_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cycles_left_q <= '0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycles_left_q <= cycles_left_d;
      first_q       <= first_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign step        = (state_q == StBusy);
  assign first_step  = first_q;
  assign done        = (state_q == StDone);
  assign cycles_left = cycles_left_q;

endmodule

// File: tb/tb_fdivsqrt_cycle_ctrl.sv
// Directed bench for fdivsqrt_cycle_ctrl with LOGR=2, DIVCOPIES=2 (4 result bits per step).
module tb_fdivsqrt_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_e;
  logic [1:0] fmt_e;
  logic       sqrt_e;
  logic       int_div_e;
  logic [7:0] int_result_bits_e;
  logic       special_case_e;
  logic       stall_m;
  logic       flush_e;
  logic       busy;
  logic       step;
  logic       first_step;
  logic       done;
  logic [5:0] cycles_e;
  logic [5:0] cycles_left;

  int n_checks = 0;
  int n_errors = 0;

  fdivsqrt_cycle_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start_e           (start_e),
    .fmt_e             (fmt_e),
    .sqrt_e            (sqrt_e),
    .int_div_e         (int_div_e),
    .int_result_bits_e (int_result_bits_e),
    .special_case_e    (special_case_e),
    .stall_m           (stall_m),
    .flush_e           (flush_e),
    .busy              (busy),
    .step              (step),
    .first_step        (first_step),
    .done              (done),
    .cycles_e          (cycles_e),
    .cycles_left       (cycles_left)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return {27'd0, busy, step, first_step, done, 1'b0} | (32'(cycles_left) << 8);
  endfunction

  task automatic set_op(input logic [1:0] fmt, input logic sq, input logic idiv,
                        input logic [7:0] ibits);
    fmt_e             = fmt;
    sqrt_e            = sq;
    int_div_e         = idiv;
    int_result_bits_e = ibits;
  endtask

  // Launch an op, count step pulses until done; optionally poke start_e mid-BUSY.
  task automatic run_op(input string tag, input logic [1:0] fmt, input logic sq,
                        input logic idiv, input logic [7:0] ibits, input int n,
                        input bit poke);
    int k;
    int steps;
    @(negedge clk);
    set_op(fmt, sq, idiv, ibits);
    special_case_e = 1'b0;
    start_e        = 1'b1;
    #1;
    check_eq({tag, " cycles_e"}, int'(cycles_e), n);
    @(negedge clk);
    start_e = 1'b0;
    check_eq({tag, " first_step"}, int'(first_step), 1);
    check_eq({tag, " cycles_left0"}, int'(cycles_left), n);
    k     = 1;
    steps = 0;
    while (!done && k < 200) begin
      steps += int'(step);
      if (k == 2) check_eq({tag, " first_step_low"}, int'(first_step), 0);
      if (poke && k == 3) begin
        start_e = 1'b1;
        fmt_e   = 2'b11;
      end else begin
        start_e = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start_e = 1'b0;
    check_eq({tag, " done"}, int'(done), 1);
    check_eq({tag, " steps"}, steps, n);
    check_eq({tag, " latency"}, k, n + 1);
    @(negedge clk);
    check_eq({tag, " idle_after"}, int'(busy), 0);
  endtask

  initial begin
    int dcnt;
    int guard;
    reset_n = 1'b0;
    start_e = 1'b0;
    set_op(2'b01, 1'b0, 1'b0, 8'd0);
    special_case_e = 1'b0;
    stall_m        = 1'b0;
    flush_e        = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset outs", outs(), 0);
    reset_n = 1'b1;

    run_op("D div", 2'b01, 1'b0, 1'b0, 8'd0, 14, 1'b0);
    run_op("D sqrt", 2'b01, 1'b1, 1'b0, 8'd0, 14, 1'b0);
    run_op("S div", 2'b00, 1'b0, 1'b0, 8'd0, 7, 1'b0);
    run_op("S sqrt", 2'b00, 1'b1, 1'b0, 8'd0, 7, 1'b0);
    run_op("H div", 2'b10, 1'b0, 1'b0, 8'd0, 4, 1'b0);
    run_op("H sqrt", 2'b10, 1'b1, 1'b0, 8'd0, 3, 1'b0);
    run_op("Q div", 2'b11, 1'b0, 1'b0, 8'd0, 29, 1'b0);
    run_op("Q sqrt", 2'b11, 1'b1, 1'b0, 8'd0, 29, 1'b0);
    run_op("int64", 2'b01, 1'b0, 1'b1, 8'd64, 16, 1'b0);
    run_op("int0", 2'b01, 1'b0, 1'b1, 8'd0, 1, 1'b0);
    run_op("int5", 2'b01, 1'b0, 1'b1, 8'd5, 2, 1'b0);
    run_op("S div poked", 2'b00, 1'b0, 1'b0, 8'd0, 7, 1'b1);

    // Special case with a 3-cycle stall: done should stay up for 4 cycles.
    @(negedge clk);
    set_op(2'b01, 1'b0, 1'b0, 8'd0);
    special_case_e = 1'b1;
    start_e        = 1'b1;
    @(negedge clk);
    start_e        = 1'b0;
    special_case_e = 1'b0;
    check_eq("special done", int'(done), 1);
    check_eq("special step", int'(step), 0);
    stall_m = 1'b1;
    dcnt    = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcnt++;
      if (i == 3) stall_m = 1'b0;
      @(negedge clk);
    end
    check_eq("stall done cycles", dcnt, 4);

    // Flush at cycles_left==7, with start_e also high: flush wins.
    @(negedge clk);
    set_op(2'b01, 1'b0, 1'b0, 8'd0);
    start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    guard   = 0;
    while (cycles_left != 6'd7 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("flush reach7", int'(cycles_left), 7);
    flush_e = 1'b1;
    start_e = 1'b1;
    @(negedge clk);
    flush_e = 1'b0;
    start_e = 1'b0;
    check_eq("flush outs", outs(), 0);
    @(negedge clk);
    check_eq("flush stays idle", outs(), 0);

    // Reset in the middle of BUSY, then a fresh op runs the full count.
    set_op(2'b01, 1'b0, 1'b0, 8'd0);
    start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre-reset busy", int'(busy), 1);
    reset_n = 1'b0;
    flush_e = 1'b1;
    stall_m = 1'b1;
    @(negedge clk);
    check_eq("mid reset outs", outs(), 0);
    reset_n = 1'b1;
    flush_e = 1'b0;
    stall_m = 1'b0;
    run_op("D after reset", 2'b01, 1'b0, 1'b0, 8'd0, 14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
